// File: rtl/cnt_wrap_monitor_if.sv
// rtl/cnt_wrap_monitor_if.sv - counter/control/status bundle for cnt_wrap_monitor
interface cnt_wrap_monitor_if #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int WCNT_WIDTH = 8
);
    logic [NUM_CH*CNT_WIDTH-1:0]  cnt_i;
    logic [NUM_CH-1:0]            en_i;
    logic [NUM_CH-1:0]            dir_i;
    logic [NUM_CH-1:0]            clr_i;
    logic [NUM_CH-1:0]            irq_mask_i;
    logic [NUM_CH-1:0]            wrap_o;
    logic [NUM_CH-1:0]            sticky_o;
    logic                         irq_o;
    logic [NUM_CH*WCNT_WIDTH-1:0] wrap_cnt_o;

    modport master (
        output cnt_i, en_i, dir_i, clr_i, irq_mask_i,
        input  wrap_o, sticky_o, irq_o, wrap_cnt_o
    );

    modport slave (
        input  cnt_i, en_i, dir_i, clr_i, irq_mask_i,
        output wrap_o, sticky_o, irq_o, wrap_cnt_o
    );
endinterface

// File: rtl/cnt_wrap_monitor.sv
// rtl/cnt_wrap_monitor.sv - per-channel counter wrap detector; CNT_WRAP_MONITOR_WCNT_EN adds wrap counters
module cnt_wrap_monitor #(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int WCNT_WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    cnt_wrap_monitor_if.slave  mon
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] cur;
    logic [NUM_CH-1:0][CNT_WIDTH-1:0] prev_q;
    logic [NUM_CH-1:0]                pv_q;
    logic [NUM_CH-1:0]                dir_q;
    logic [NUM_CH-1:0]                wrap_q;
    logic [NUM_CH-1:0]                sticky_q;
    logic [NUM_CH-1:0]                det;

    // Only the exact max->0 (up) or 0->max (down) step counts, and only when the
    // previous sample was taken while enabled and in the same direction.
    always_comb begin
        cur = '0;
        det = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            cur[n] = mon.cnt_i[n*CNT_WIDTH +: CNT_WIDTH];
            det[n] = mon.en_i[n] && pv_q[n] && (mon.dir_i[n] == dir_q[n]) &&
                     (mon.dir_i[n] ? (prev_q[n] == '0 && cur[n] == CNT_MAX)
                                   : (prev_q[n] == CNT_MAX && cur[n] == '0));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= '0;
            pv_q     <= '0;
            dir_q    <= '0;
            wrap_q   <= '0;
            sticky_q <= '0;
        end else begin
            dir_q  <= mon.dir_i;
            wrap_q <= det;
            for (int n = 0; n < NUM_CH; n++) begin
                if (mon.en_i[n]) begin
                    prev_q[n] <= cur[n];
                    pv_q[n]   <= (mon.dir_i[n] == dir_q[n]);
                end else begin
                    pv_q[n] <= 1'b0;
                end
                // A wrap on the clear edge keeps the flag set.
                if (det[n]) begin
                    sticky_q[n] <= 1'b1;
                end else if (mon.clr_i[n]) begin
                    sticky_q[n] <= 1'b0;
                end
            end
        end
    end

    assign mon.wrap_o   = wrap_q;
    assign mon.sticky_o = sticky_q;
    assign mon.irq_o    = |(sticky_q & mon.irq_mask_i);

`ifdef CNT_WRAP_MONITOR_WCNT_EN
    localparam logic [WCNT_WIDTH-1:0] WCNT_MAX = '1;

    logic [NUM_CH-1:0][WCNT_WIDTH-1:0] wcnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wcnt_q <= '0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (det[n]) begin
                    if (mon.clr_i[n]) begin
                        wcnt_q[n] <= WCNT_WIDTH'(1);
                    end else if (wcnt_q[n] != WCNT_MAX) begin
                        wcnt_q[n] <= wcnt_q[n] + WCNT_WIDTH'(1);
                    end
                end else if (mon.clr_i[n]) begin
                    wcnt_q[n] <= '0;
                end
            end
        end
    end

    assign mon.wrap_cnt_o = wcnt_q;
`else
    assign mon.wrap_cnt_o = {NUM_CH*WCNT_WIDTH{1'b0}};
`endif
endmodule

// File: tb/tb_cnt_wrap_monitor.sv
// tb/tb_cnt_wrap_monitor.sv - directed and randomized checks of cnt_wrap_monitor against a history model
module tb_cnt_wrap_monitor;
    localparam int NC   = 4;
    localparam int CW   = 8;
    localparam int WW   = 2;
    localparam int MAXV = 255;
    localparam int WMAX = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnt_wrap_monitor_if #(.NUM_CH(NC), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) bus ();

    cnt_wrap_monitor #(.NUM_CH(NC), .CNT_WIDTH(CW), .WCNT_WIDTH(WW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .mon   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [CW-1:0] v_cnt [NC];
    logic [NC-1:0] v_en, v_dir, v_clr, v_mask;

    // Model: history of the last two applied vectors per channel plus flag/count state
    bit      m_e1 [NC];
    bit      m_d1 [NC];
    bit      m_d2 [NC];
    int      m_c1 [NC];
    int      m_wcnt [NC];
    bit [NC-1:0] m_sticky, m_wrap;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < NC; n++) begin
            m_e1[n] = 0; m_d1[n] = 0; m_d2[n] = 0; m_c1[n] = 0; m_wcnt[n] = 0;
        end
        m_sticky = '0;
        m_wrap   = '0;
    endtask

    function automatic logic [NC*WW-1:0] exp_wcnt();
        logic [NC*WW-1:0] r;
        r = '0;
`ifdef CNT_WRAP_MONITOR_WCNT_EN
        for (int n = 0; n < NC; n++) r[n*WW +: WW] = WW'(m_wcnt[n]);
`endif
        return r;
    endfunction

    task automatic apply();
        logic [NC*CW-1:0] pc;
        for (int n = 0; n < NC; n++) pc[n*CW +: CW] = v_cnt[n];
        bus.cnt_i      = pc;
        bus.en_i       = v_en;
        bus.dir_i      = v_dir;
        bus.clr_i      = v_clr;
        bus.irq_mask_i = v_mask;
        for (int n = 0; n < NC; n++) begin
            bit w;
            w = v_en[n] && m_e1[n] && (v_dir[n] == m_d1[n]) && (m_d1[n] == m_d2[n]) &&
                ((!v_dir[n] && m_c1[n] == MAXV && int'(v_cnt[n]) == 0) ||
                 ( v_dir[n] && m_c1[n] == 0 && int'(v_cnt[n]) == MAXV));
            m_wrap[n] = w;
            if (w) m_sticky[n] = 1'b1;
            else if (v_clr[n]) m_sticky[n] = 1'b0;
            if (w) m_wcnt[n] = v_clr[n] ? 1 : ((m_wcnt[n] < WMAX) ? m_wcnt[n] + 1 : WMAX);
            else if (v_clr[n]) m_wcnt[n] = 0;
            m_d2[n] = m_d1[n];
            m_d1[n] = v_dir[n];
            m_e1[n] = v_en[n];
            m_c1[n] = int'(v_cnt[n]);
        end
        @(posedge clk);
        @(negedge clk);
        chk("wrap",     64'(bus.wrap_o),     64'(m_wrap));
        chk("sticky",   64'(bus.sticky_o),   64'(m_sticky));
        chk("irq",      64'(bus.irq_o),      64'(|(m_sticky & v_mask)));
        chk("wrap_cnt", 64'(bus.wrap_cnt_o), 64'(exp_wcnt()));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wrap"},   64'(bus.wrap_o),     64'(0));
        chk({tag, "_sticky"}, 64'(bus.sticky_o),   64'(0));
        chk({tag, "_irq"},    64'(bus.irq_o),      64'(0));
        chk({tag, "_wcnt"},   64'(bus.wrap_cnt_o), 64'(0));
    endtask

    initial begin
        for (int n = 0; n < NC; n++) v_cnt[n] = 8'h10;
        v_en = '1; v_dir = '0; v_clr = '0; v_mask = '1;
        bus.cnt_i = '0; bus.en_i = '0; bus.dir_i = '0; bus.clr_i = '0; bus.irq_mask_i = '0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Up-wrap on ch0; first edge after reset never detects
        v_cnt[0] = 8'hFE; apply();
        v_cnt[0] = 8'hFF; apply();
        v_cnt[0] = 8'h00; apply();
        chk("up_wrap_pulse", 64'(bus.wrap_o[0]), 64'(1));
        chk("up_wrap_irq",   64'(bus.irq_o),     64'(1));
        v_cnt[0] = 8'h01; apply();
        chk("up_wrap_one_cycle", 64'(bus.wrap_o[0]), 64'(0));

        // Down-wrap on ch1, then a non-exact jump
        v_dir[1] = 1'b1;
        v_cnt[1] = 8'h01; apply();
        v_cnt[1] = 8'h00; apply();
        v_cnt[1] = 8'hFF; apply();
        chk("down_wrap_pulse", 64'(bus.wrap_o[1]), 64'(1));
        v_cnt[1] = 8'h00; apply();
        v_cnt[1] = 8'hFE; apply();
        chk("down_no_wrap", 64'(bus.wrap_o[1]), 64'(0));

        // Enable gating then direction toggle on ch2
        v_cnt[2] = 8'hFF; apply();
        v_en[2] = 1'b0; apply();
        v_en[2] = 1'b1; v_cnt[2] = 8'h00; apply();
        chk("en_gate", 64'(bus.wrap_o[2]), 64'(0));
        v_cnt[2] = 8'hFF; apply(); apply();
        v_dir[2] = 1'b1; v_cnt[2] = 8'h00; apply();
        chk("dir_gate", 64'(bus.wrap_o[2]), 64'(0));
        v_dir[2] = 1'b0; v_cnt[2] = 8'h10; apply();

        // Clear versus set on ch0
        v_mask = 4'b0001;
        v_cnt[0] = 8'hFF; apply();
        v_cnt[0] = 8'h00; v_clr[0] = 1'b1; apply();
        chk("clr_vs_set", 64'(bus.sticky_o[0]), 64'(1));
        v_cnt[0] = 8'h05; apply();
        v_clr[0] = 1'b0; apply();
        chk("clr_alone_sticky", 64'(bus.sticky_o[0]), 64'(0));
        chk("clr_alone_irq",    64'(bus.irq_o),       64'(0));

        // Five wraps on ch0 saturate the 2-bit counter
        v_clr = 4'b1110; apply();
        v_clr = '0;
        for (int i = 0; i < 5; i++) begin
            v_cnt[0] = 8'hFF; apply();
            v_cnt[0] = 8'h00; apply();
        end
`ifdef CNT_WRAP_MONITOR_WCNT_EN
        chk("wcnt_sat", 64'(bus.wrap_cnt_o[WW-1:0]), 64'(3));
`else
        chk("wcnt_off", 64'(bus.wrap_cnt_o), 64'(0));
`endif

        // Reset mid-sequence on ch3
        v_cnt[3] = 8'hFF; apply();
        v_cnt[0] = 8'hFF; apply();
        #2 rst = 1'b1;
        #1 model_reset();
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        v_cnt[3] = 8'h00; v_cnt[0] = 8'h00; apply();
        check_all_zero("post_rst");

        // Randomized traffic biased towards wrap boundaries
        for (int i = 0; i < 400; i++) begin
            for (int n = 0; n < NC; n++) begin
                case ($urandom_range(3))
                    0: v_cnt[n] = 8'h00;
                    1: v_cnt[n] = 8'hFF;
                    2: v_cnt[n] = ($urandom_range(1) != 0) ? 8'h01 : 8'hFE;
                    default: v_cnt[n] = 8'($urandom);
                endcase
                v_en[n]  = ($urandom_range(7) != 0);
                if ($urandom_range(15) == 0) v_dir[n] = ~v_dir[n];
                v_clr[n] = ($urandom_range(9) == 0);
            end
            v_mask = 4'($urandom);
            apply();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cnt_wrap_monitor.md
CNT_WRAP_MONITOR -- requirements
Module: cnt_wrap_monitor

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of monitored counter channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32, width of each monitored counter (2..64).
REQ-003 SHALL have parameter WCNT_WIDTH, default 8, width of each per-channel wrap event counter (1..16).
REQ-004 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cnt_i, input, NUM_CH*CNT_WIDTH, packed counter values; channel n at [n*CNT_WIDTH +: CNT_WIDTH].
REQ-007 SHALL have port en_i, input, NUM_CH, per-channel monitor enable.
REQ-008 SHALL have port dir_i, input, NUM_CH, per-channel count direction (0 = up, 1 = down).
REQ-009 SHALL have port clr_i, input, NUM_CH, per-channel write-1-to-clear of sticky flag and wrap counter.
REQ-010 SHALL have port irq_mask_i, input, NUM_CH, per-channel interrupt enable.
REQ-011 SHALL have port wrap_o, output, NUM_CH, per-channel one-cycle wrap pulse.
REQ-012 SHALL have port sticky_o, output, NUM_CH, per-channel sticky wrap flag.
REQ-013 SHALL have port irq_o, output, 1, OR of (sticky_o & irq_mask_i).
REQ-014 SHALL have port wrap_cnt_o, output, NUM_CH*WCNT_WIDTH, packed per-channel wrap counts (present only per REQ-030).

Function
REQ-015 SHALL keep per channel a registered previous sample prev[n] and valid bit pv[n]; each enabled cycle prev[n] <= cnt_i[n], pv[n] <= 1.
REQ-016 SHALL, when en_i[n] = 0, clear pv[n], hold prev[n], and generate no wrap for channel n.
REQ-017 SHALL detect up-wrap when dir_i[n] = 0, en_i[n] = 1, pv[n] = 1, prev[n] = all-ones, cnt_i[n] = 0.
REQ-018 SHALL detect down-wrap when dir_i[n] = 1, en_i[n] = 1, pv[n] = 1, prev[n] = 0, cnt_i[n] = all-ones.
REQ-019 SHALL clear pv[n] on the edge where dir_i[n] differs from its previous registered value, suppressing detection on that edge.
REQ-020 SHALL register wrap_o[n] high for exactly one cycle following the edge at which detection is true (latency 1 clock); back-to-back wraps give back-to-back pulses.
REQ-021 SHALL not flag a hold at max/0 or any jump other than the exact pairs of REQ-017/018 (e.g. max->1 is no wrap).
REQ-022 SHALL set sticky_o[n] on the same edge wrap_o[n] rises; held until cleared.
REQ-023 SHALL clear sticky_o[n] on an edge with clr_i[n] = 1; if a wrap is detected on the same edge, set wins and sticky_o[n] stays 1.
REQ-024 SHALL drive irq_o combinationally from sticky_o and irq_mask_i; no extra latency.
REQ-025 SHALL treat channels fully independently; simultaneous wraps on all channels are all recorded.

Reset
REQ-026 SHALL, on rst_i = 1, asynchronously clear prev, pv, registered dir, wrap_o, sticky_o, wrap counters; irq_o = 0.
REQ-027 SHALL not detect a wrap on the first enabled edge after reset release (pv = 0).
REQ-028 SHALL abort any in-flight pulse on reset mid-operation; no pulse after release unless a new wrap pair occurs.

Configuration
REQ-029 SHALL use macro CNT_WRAP_MONITOR_WCNT_EN.
REQ-030 SHALL, with the macro defined, implement per-channel WCNT_WIDTH-bit wrap counters incrementing on each wrap_o pulse, saturating at all-ones, cleared by clr_i[n] (wrap same edge: counter loads 1), driven on wrap_cnt_o.
REQ-031 SHALL, without the macro, omit the counters and tie wrap_cnt_o to 0; all other behaviour unchanged.

Verification
REQ-032 SHALL cover up-wrap: NUM_CH=4, CNT_WIDTH=8, ch0 up, cnt 0xFE,0xFF,0x00 -> wrap_o[0] one cycle after 0x00 edge, sticky_o[0]=1, irq_o=1 with mask[0]=1.
REQ-033 SHALL cover down-wrap: ch1 dir=1, cnt 0x01,0x00,0xFF -> wrap_o[1] pulse; cnt 0x00,0xFE -> no pulse.
REQ-034 SHALL cover enable/dir gating: ch2 0xFF, en low one cycle, then 0x00 -> no pulse; dir toggled on the 0xFF->0x00 edge -> no pulse.
REQ-035 SHALL cover clear vs set: clr_i[0]=1 on wrap edge -> sticky_o[0] stays 1; clr_i[0]=1 alone -> sticky_o[0]=0, irq_o=0.
REQ-036 SHALL cover reset: rst_i asserted mid-sequence 0xFF, release, drive 0x00 -> no pulse, all outputs 0.
REQ-037 SHALL cover counter saturation (macro defined, WCNT_WIDTH=2): 5 wraps -> wrap_cnt_o[0]=3; undefined -> wrap_cnt_o=0.
